mext_iter_unit: RTL and testbench

- Parametrised multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), instantiated inside the EX stage beside the ALU and CMP.
- Consumes forwarded rs1/rs2 operands.
- Raises pause to stall IF/ID/EX while it iterates.
- Holds its result until the pipeline advances out of EX.

---
 rtl/rv32i_types.sv | 41 ++++
 rtl/mext_div_step.sv | 38 +++
 rtl/mext_iter_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mext_iter_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32 types for the M-extension execute unit
// Purpose: operation and state encodings for mext_iter_unit, plus op-class decode helpers.
// Ports: none (package).
package rv32i_types;

  // Encoding follows the RV32M funct3 field.
  typedef enum logic [2:0] {
    mul    = 3'd0,
    mulh   = 3'd1,
    mulhsu = 3'd2,
    mulhu  = 3'd3,
    div    = 3'd4,
    divu   = 3'd5,
    rem    = 3'd6,
    remu   = 3'd7
  } mulop_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY,
    DONE
  } mext_state_t;

  function automatic logic op_is_div(input mulop_t op);
    return op inside {div, divu, rem, remu};
  endfunction

  function automatic logic op_is_rem(input mulop_t op);
    return op inside {rem, remu};
  endfunction

  function automatic logic op_signed_a(input mulop_t op);
    return op inside {mulh, mulhsu, div, rem};
  endfunction

  function automatic logic op_signed_b(input mulop_t op);
    return op inside {mulh, div, rem};
  endfunction

endpackage

// File: rtl/mext_div_step.sv
// rtl/mext_div_step.sv - combinational non-restoring division step, DIV_BITS quotient bits
// Purpose: advances a magnitude division by DIV_BITS bits.
// Ports: rem_in/rem_out  signed partial remainder (XLEN+1 bits)
//        quo_in/quo_out  dividend bits shifting out, quotient bits shifting in
//        dvsr            divisor magnitude
module mext_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;
  logic [XLEN+1:0] t;

  always_comb begin
    r = rem_in;
    q = quo_in;
    t = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      // 2r+bit needs one extra bit before the add/sub pulls it back into range.
      t = {r, q[XLEN-1]};
      if (r[XLEN]) t = t + {2'b00, dvsr};
      else         t = t - {2'b00, dvsr};
      r = t[XLEN:0];
      // Quotient bit is set when the new partial remainder is non-negative.
      q = {q[XLEN-2:0], ~t[XLEN+1]};
    end
    rem_out = r;
    quo_out = q;
  end

endmodule

// File: rtl/mext_iter_unit.sv
// rtl/mext_iter_unit.sv - multi-cycle RV32M multiply/divide unit for the EX stage
// Purpose: iterates MUL*/DIV*/REM* on forwarded operands, stalling the pipe via pause
//          and holding the result until EX advances.
// Ports: clk, rst (async, active-high); enable (M op in EX); mulop; rs1/rs2 operands;
//        advance (EX/MEM loads); flush (squash EX); out (valid when enable && !pause);
//        pause (stall request).
// Option: MEXT_RESULT_CACHE_EN keeps the last product / quotient-remainder pair so a
//         matching follow-up op completes without iterating.
module mext_iter_unit
  import rv32i_types::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  mulop_t          mulop,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            advance,
  input  logic            flush,
  output logic [XLEN-1:0] out,
  output logic            pause
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_CYCLES = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0] DIV_CYCLES = CW'(XLEN / DIV_BITS);

  mext_state_t       state, state_n;
  logic [CW-1:0]     cnt;
  mulop_t            op_q;
  logic              neg_q, rneg_q;
  logic [2*XLEN-1:0] mcand, acc, acc_nxt, prod;
  logic [XLEN-1:0]   mplier, quo, dvsr, quo_nxt, rem_mag, quo_s, rem_s, out_q;
  logic [XLEN:0]     prem, prem_nxt;

  logic            sa, sb, a_neg, b_neg, op_div, div_zero, div_ovf, special, hit, last;
  logic [XLEN-1:0] a_mag, b_mag, special_res, hit_res;

  // Operand decode, only meaningful while sampling in IDLE.
  assign sa       = op_signed_a(mulop);
  assign sb       = op_signed_b(mulop);
  assign a_neg    = sa & rs1[XLEN-1];
  assign b_neg    = sb & rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;
  assign op_div   = op_is_div(mulop);
  assign div_zero = (rs2 == '0);
  assign div_ovf  = sa && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
  assign special  = op_div && (div_zero || div_ovf);
  assign special_res = op_is_rem(mulop) ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);
  assign last     = (cnt == CW'(1));

  // Shift-add multiply on magnitudes; sign fix-up applies to the final sum.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < MUL_BITS; i++)
      if (mplier[i]) acc_nxt = acc_nxt + (mcand << i);
    prod = neg_q ? -acc_nxt : acc_nxt;
  end

  mext_div_step #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_div_step (
    .rem_in (prem),
    .quo_in (quo),
    .dvsr   (dvsr),
    .rem_out(prem_nxt),
    .quo_out(quo_nxt)
  );

  // Non-restoring leaves a negative remainder one divisor short.
  assign rem_mag = prem_nxt[XLEN] ? (prem_nxt[XLEN-1:0] + dvsr) : prem_nxt[XLEN-1:0];
  assign quo_s   = neg_q  ? -quo_nxt : quo_nxt;
  assign rem_s   = rneg_q ? -rem_mag : rem_mag;

`ifdef MEXT_RESULT_CACHE_EN
  logic              c_valid, c_div, c_sa, c_sb;
  logic [XLEN-1:0]   c_a, c_b;
  logic [2*XLEN-1:0] c_data;  // full product, or {remainder, quotient}

  assign hit = c_valid && (c_div == op_div) && (c_sa == sa) && (c_sb == sb) &&
               (c_a == rs1) && (c_b == rs2);
  assign hit_res = (op_is_rem(mulop) || (!op_div && mulop != mul)) ?
                   c_data[2*XLEN-1:XLEN] : c_data[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_div   <= 1'b0;
      c_sa    <= 1'b0;
      c_sb    <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_data  <= '0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && !hit) begin
          c_valid <= 1'b0;
          c_div   <= op_div;
          c_sa    <= sa;
          c_sb    <= sb;
          c_a     <= rs1;
          c_b     <= rs2;
        end
        MUL_BUSY: if (last) begin
          c_valid <= 1'b1;
          c_data  <= prod;
        end
        DIV_BUSY: if (last) begin
          c_valid <= 1'b1;
          c_data  <= {rem_s, quo_s};
        end
        default: ;
      endcase
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (enable) begin
        if (special || hit) state_n = DONE;
        else                state_n = op_div ? DIV_BUSY : MUL_BUSY;
      end
      MUL_BUSY, DIV_BUSY: if (last) state_n = DONE;
      DONE: if (advance) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= mul;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      prem   <= '0;
      quo    <= '0;
      dvsr   <= '0;
      out_q  <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (enable) begin
          op_q   <= mulop;
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          cnt    <= op_div ? DIV_CYCLES : MUL_CYCLES;
          mcand  <= {{XLEN{1'b0}}, a_mag};
          mplier <= b_mag;
          acc    <= '0;
          prem   <= '0;
          quo    <= a_mag;
          dvsr   <= b_mag;
          if (special)  out_q <= special_res;
          else if (hit) out_q <= hit_res;
        end
        MUL_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt - CW'(1);
          if (last) out_q <= (op_q == mul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        DIV_BUSY: begin
          prem <= prem_nxt;
          quo  <= quo_nxt;
          cnt  <= cnt - CW'(1);
          if (last) out_q <= op_is_rem(op_q) ? rem_s : quo_s;
        end
        default: ;
      endcase
    end
  end

  assign out   = out_q;
  assign pause = !rst && enable && (state != DONE);

`ifndef SYNTHESIS
  busy_needs_enable: assert property (@(posedge clk) disable iff (rst)
    ((state == MUL_BUSY || state == DIV_BUSY) && !flush) |-> enable);
`endif

endmodule

// File: tb/tb_mext_iter_unit.sv
// tb/tb_mext_iter_unit.sv - self-checking bench for mext_iter_unit against an arithmetic model
module tb_mext_iter_unit;
  import rv32i_types::*;

  localparam int MUL_LAT = 32 / 4 + 1;
  localparam int DIV_LAT = 32 / 1 + 1;

  logic        clk, rst, enable, advance, flush, pause;
  mulop_t      mulop;
  logic [31:0] rs1, rs2, out;

  int checks = 0;
  int failures = 0;

`ifdef MEXT_RESULT_CACHE_EN
  bit          c_valid = 0;
  bit          c_div, c_sa, c_sb;
  logic [31:0] c_a, c_b;
`endif

  mext_iter_unit #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mulop(mulop), .rs1(rs1), .rs2(rs2),
    .advance(advance), .flush(flush), .out(out), .pause(pause)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_result(input mulop_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      mul:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      mulh:   begin p = 64'(longint'(int'(a)) * longint'(int'(b))); r = p[63:32]; end
      mulhsu: begin p = 64'(longint'(int'(a)) * longint'({32'b0, b})); r = p[63:32]; end
      mulhu:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      div:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(int'(a) / int'(b));
      divu:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      rem:    r = (b == 0) ? a : ovf ? 32'h0 : 32'(int'(a) % int'(b));
      remu:   r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic cache_drop();
`ifdef MEXT_RESULT_CACHE_EN
    c_valid = 0;
`endif
  endtask

  // Starts at a falling edge; runs one op to completion, holds, then retires it.
  task automatic do_op(input mulop_t op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit use_flush, input bit gap, input string tag);
    bit is_div, s_a, hit, special;
    int n, lat;
    logic [31:0] want;
    is_div  = op inside {div, divu, rem, remu};
    s_a     = op inside {mulh, mulhsu, div, rem};
    special = is_div && (b == 0 || (s_a && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    hit     = 0;
`ifdef MEXT_RESULT_CACHE_EN
    hit = c_valid && c_div == is_div && c_sa == s_a && c_sb == (op inside {mulh, div, rem}) &&
          c_a == a && c_b == b;
`endif
    lat  = (special || hit) ? 1 : (is_div ? DIV_LAT : MUL_LAT);
    want = ref_result(op, a, b);

    mulop = op; rs1 = a; rs2 = b; enable = 1; advance = 0; flush = 0;
    #1;
    n = 0;
    while (pause && n < 200) begin
      n++;
      @(negedge clk); #1;
      if (pause) begin
        rs1 = $urandom; rs2 = $urandom; mulop = mulop_t'(3'($urandom_range(0, 7)));
      end
    end
    expect_eq({tag, "_lat"}, 32'(n), 32'(lat));
    expect_eq({tag, "_out"}, out, want);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      expect_eq({tag, "_hold_out"}, out, want);
      expect_eq({tag, "_hold_pause"}, 32'(pause), 32'd0);
    end

`ifdef MEXT_RESULT_CACHE_EN
    if (!hit) begin
      c_valid = !special;
      c_div = is_div; c_sa = s_a; c_sb = op inside {mulh, div, rem}; c_a = a; c_b = b;
    end
`endif
    if (use_flush) begin flush = 1; cache_drop(); end
    else advance = 1;
    @(negedge clk);
    flush = 0; advance = 0;
    if (gap) begin
      enable = 0;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; enable = 1; mulop = mul; rs1 = 0; rs2 = 0; advance = 0; flush = 0;
    repeat (2) @(negedge clk);
    #1;
    expect_eq("reset_out", out, 32'h0);
    expect_eq("reset_pause", 32'(pause), 32'd0);
    enable = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);

    do_op(mul,    32'd7,          32'hFFFF_FFFD, 1, 0, 1, "mul_7x-3");
    do_op(mulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, 1, "mulhu_ff");
    do_op(mulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, 0, "mulhsu_ff");
    do_op(div,    32'hFFFF_FFF9,  32'd2,         0, 0, 1, "div_-7_2");
    do_op(rem,    32'hFFFF_FFF9,  32'd2,         0, 0, 1, "rem_-7_2");
    do_op(divu,   32'd5,          32'd0,         0, 0, 1, "divu_5_0");
    do_op(rem,    32'd5,          32'd0,         0, 0, 0, "rem_5_0");
    do_op(div,    32'h8000_0000,  32'hFFFF_FFFF, 0, 0, 1, "div_ovf");
    do_op(mulh,   32'h1234_5678,  32'h8765_4321, 3, 1, 0, "done_flush");
    do_op(mul,    32'hDEAD_BEEF,  32'h0000_1001, 0, 0, 1, "mul_after_flush");

    // Squash a divide in cycle 5 of its iteration.
    mulop = div; rs1 = 32'd1000; rs2 = 32'd3; enable = 1;
    repeat (5) @(negedge clk);
    #1;
    expect_eq("flush_div_pause_pre", 32'(pause), 32'd1);
    flush = 1;
    cache_drop();
    @(negedge clk);
    flush = 0; enable = 0;
    #1;
    expect_eq("flush_div_pause_post", 32'(pause), 32'd0);
    @(negedge clk);
    do_op(mul, 32'hFFFF_FFF0, 32'd9, 0, 0, 1, "mul_after_div_flush");

    do_op(div, 32'd100, 32'd7, 0, 0, 1, "div_100_7");
    do_op(rem, 32'd100, 32'd7, 0, 0, 1, "rem_100_7");
    do_op(mulhu, 32'hABCD_0123, 32'h0F0F_F0F0, 0, 0, 1, "mulhu_pair");
    do_op(mul,   32'hABCD_0123, 32'h0F0F_F0F0, 0, 0, 1, "mul_pair");

    // Asynchronous reset in the middle of a divide.
    mulop = divu; rs1 = 32'hFFFF_0000; rs2 = 32'd13; enable = 1;
    repeat (10) @(negedge clk);
    #1;
    rst = 1;
    cache_drop();
    #1;
    expect_eq("rst_mid_out", out, 32'h0);
    expect_eq("rst_mid_pause", 32'(pause), 32'd0);
    @(negedge clk); enable = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    do_op(remu, 32'hFFFF_0000, 32'd13, 0, 0, 1, "remu_after_rst");

    for (int k = 0; k < 40; k++) begin
      mulop_t op;
      logic [31:0] a, b;
      op = mulop_t'(3'($urandom_range(0, 7)));
      a = pick();
      b = pick();
      do_op(op, a, b, $urandom_range(0, 2), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0)
        do_op(mulop_t'(3'($urandom_range(0, 7))), a, b, 0, 0, 1, "rand_same");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
